dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 25 ++
 rtl/dmem_lsu_align.sv | 35 +++
 rtl/dmem_lsu.sv | 121 ++++++++++++
 tb/tb_dmem_lsu.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared op codes, FSM encodings and address-map defaults for the dmem load/store unit.
package dmem_lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [31:0] DATA_BASE_DEF = 32'h1001_0000;

  function automatic logic op_is_load(logic [2:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

endpackage

// File: rtl/dmem_lsu_align.sv
// Little-endian lane extraction/extension for loads and byte/half merge for sub-word stores.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [1:0]  bo_i,
  input  logic [31:0] word_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] ld_val_o,
  output logic [31:0] st_word_o
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;

  assign sh   = {bo_i, 3'b000};
  assign lane = word_i >> sh;

  always_comb begin
    ld_val_o = word_i;
    case (op_i)
      OP_LB:   ld_val_o = {{24{lane[7]}}, lane[7:0]};
      OP_LBU:  ld_val_o = {24'd0, lane[7:0]};
      OP_LH:   ld_val_o = {{16{lane[15]}}, lane[15:0]};
      OP_LHU:  ld_val_o = {16'd0, lane[15:0]};
      default: ld_val_o = word_i;
    endcase
  end

  // SW never reaches the merge path, so anything but SB is treated as a halfword
  assign mask      = ((op_i == OP_SB) ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
  assign st_word_o = (word_i & ~mask) | ((wdata_i << sh) & mask);

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed CPU load/store front end for a word-wide data memory (RMW for sub-word stores).
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter logic [31:0] DATA_BASE   = DATA_BASE_DEF,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic          resp_err,
  output logic [31:0]   resp_rdata,
  output logic          dmem_ena,
  output logic          dmem_read,
  output logic          dmem_write,
  output logic [AW-1:0] dmem_addr,
  output logic [31:0]   dmem_wdata,
  input  logic [31:0]   dmem_rdata
);

  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  logic [1:0]    state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] idx_q, addr_hold_q;
  logic [1:0]    bo_q;
  logic          err_q;
  logic [31:0]   wbuf_q, wd_hold_q, rdata_q;

  logic [31:0]   off;
  logic          mis, bad_op, req_err, in_rd, in_wr, accept;
  logic [31:0]   ld_val, st_word;

  assign off = req_addr - DATA_BASE;

  always_comb begin
    mis    = 1'b0;
    bad_op = 1'b0;
    case (req_op)
      OP_LW, OP_SW:         mis = |off[1:0];
      OP_LH, OP_LHU, OP_SH: mis = off[0];
      OP_LB, OP_LBU, OP_SB: mis = 1'b0;
      default:              bad_op = 1'b1;
    endcase
  end

  // below-base addresses wrap to huge offsets and fall out of range here
  assign req_err = mis | bad_op | (off >= LIMIT);
  assign accept  = (state_q == S_IDLE) && req_valid;
  assign in_rd   = (state_q == S_RD);
  assign in_wr   = (state_q == S_WR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_err ? S_RESP : (req_op == OP_SW) ? S_WR : S_RD;
      S_RD:    state_d = op_is_load(op_q) ? S_RESP : S_WR;
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  dmem_lsu_align u_align (
    .op_i      (op_q),
    .bo_i      (bo_q),
    .word_i    (dmem_rdata),
    .wdata_i   (wbuf_q),
    .ld_val_o  (ld_val),
    .st_word_o (st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= '0;
      idx_q       <= '0;
      bo_q        <= '0;
      err_q       <= 1'b0;
      wbuf_q      <= '0;
      rdata_q     <= '0;
      addr_hold_q <= '0;
      wd_hold_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q   <= req_op;
        idx_q  <= off[AW+1:2];
        bo_q   <= off[1:0];
        wbuf_q <= req_wdata;
        err_q  <= req_err;
      end
      // wbuf_q carries raw store data until RD overwrites it with the merged word
      if (in_rd) begin
        addr_hold_q <= idx_q;
        if (op_is_load(op_q)) rdata_q <= ld_val;
        else                  wbuf_q  <= st_word;
      end
      if (in_wr) begin
        addr_hold_q <= idx_q;
        wd_hold_q   <= wbuf_q;
      end
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_err   = (state_q == S_RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign dmem_ena   = in_rd | in_wr;
  assign dmem_read  = in_rd;
  assign dmem_write = in_wr;
  assign dmem_addr  = (in_rd | in_wr) ? idx_q : addr_hold_q;
  assign dmem_wdata = in_wr ? wbuf_q : wd_hold_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Randomised + directed bench for dmem_lsu against a byte-array memory model.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_ena, dmem_read, dmem_write;
  logic [10:0] dmem_addr;
  logic [31:0] dmem_wdata, dmem_rdata;

  logic [31:0] mem [0:2047];
  logic        pl_en = 1'b0;
  logic [10:0] pl_idx = '0;
  logic [31:0] pl_data = '0;

  logic [7:0]  rb [0:4095];
  logic [31:0] last_rd;
  int          total = 0, pass = 0;

  always #5 clk = ~clk;

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .dmem_ena(dmem_ena), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  assign dmem_rdata = mem[dmem_addr];
  always @(posedge clk)
    if (pl_en) mem[pl_idx] <= pl_data;
    else if (dmem_ena && dmem_write) mem[dmem_addr] <= dmem_wdata;

  // ---------------- reference model (byte-addressed) ----------------
  function automatic bit m_err(logic [2:0] op, logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    if (o >= 32'd4096) return 1'b1;
    if ((op == OP_LW || op == OP_SW) && (o % 4) != 0) return 1'b1;
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && (o % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_is_load(logic [2:0] op);
    return op <= OP_LBU;
  endfunction

  function automatic int m_lat(logic [2:0] op, bit e);
    if (e) return 1;
    if (op == OP_SB || op == OP_SH) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] m_word(int i);
    return 32'(rb[4*i]) + 32'(rb[4*i+1]) * 256 + 32'(rb[4*i+2]) * 65536 + 32'(rb[4*i+3]) * 16777216;
  endfunction

  function automatic logic [31:0] m_load(logic [2:0] op, logic [31:0] a);
    int o;
    logic [31:0] v;
    o = int'(a - BASE);
    v = 32'(rb[o]);
    if (op == OP_LW) v = v + 32'(rb[o+1]) * 256 + 32'(rb[o+2]) * 65536 + 32'(rb[o+3]) * 16777216;
    if (op == OP_LH || op == OP_LHU) v = v + 32'(rb[o+1]) * 256;
    if (op == OP_LB && v >= 32'd128) v = v + 32'hFFFF_FF00;
    if (op == OP_LH && v >= 32'd32768) v = v + 32'hFFFF_0000;
    return v;
  endfunction

  task automatic m_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
    int o, n;
    if (m_err(op, a)) return;
    o = int'(a - BASE);
    if (m_is_load(op)) begin
      last_rd = m_load(op, a);
      return;
    end
    n = (op == OP_SW) ? 4 : (op == OP_SH) ? 2 : 1;
    for (int i = 0; i < n; i++) rb[o+i] = 8'(wd >> (8*i));
  endtask

  task automatic poke(input int idx, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = 11'(idx); pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    for (int i = 0; i < 4; i++) rb[4*idx+i] = 8'(d >> (8*i));
  endtask

  // drive one request, then observe until resp_valid (bounded)
  task automatic do_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output int nrd, output int nwr, output logic [10:0] waddr);
    int g;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    req_valid = 1'b1; req_op = op; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; err = 1'bx; rd = 'x; waddr = '0;
    for (int c = 0; c < 8; c++) begin
      if (dmem_ena && dmem_read) nrd++;
      if (dmem_ena && dmem_write) begin nwr++; waddr = dmem_addr; end
      if (resp_valid) begin err = resp_err; rd = resp_rdata; break; end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    total++;
    if ({req_ready, resp_valid, resp_err, dmem_ena, dmem_read, dmem_write} !== 6'b100000)
      $display("FAIL reset_ctl: got %b want 100000",
               {req_ready, resp_valid, resp_err, dmem_ena, dmem_read, dmem_write});
    else pass++;
    total++;
    if (resp_rdata !== 32'd0 || dmem_addr !== 11'd0 || dmem_wdata !== 32'd0)
      $display("FAIL reset_data: rdata=%h addr=%h wdata=%h want 0", resp_rdata, dmem_addr, dmem_wdata);
    else pass++;
  endtask

  task automatic test_loads;
    int lat, nrd, nwr; logic err; logic [31:0] rd; logic [10:0] wa;
    poke(0, 32'h8899_AABB);
    do_req(OP_LB, 32'h1001_0001, 32'd0, lat, err, rd, nrd, nwr, wa); m_apply(OP_LB, 32'h1001_0001, 0);
    total++;
    if (rd !== 32'hFFFF_FFAA || lat != 2 || err !== 1'b0 || nrd != 1)
      $display("FAIL lb_sign: rdata=%h lat=%0d err=%b rd=%0d want ffffffaa 2 0 1", rd, lat, err, nrd);
    else pass++;
    do_req(OP_LBU, 32'h1001_0001, 32'd0, lat, err, rd, nrd, nwr, wa); m_apply(OP_LBU, 32'h1001_0001, 0);
    total++;
    if (rd !== 32'h0000_00AA || lat != 2) $display("FAIL lbu: rdata=%h lat=%0d want 000000aa 2", rd, lat);
    else pass++;
    do_req(OP_LHU, 32'h1001_0002, 32'd0, lat, err, rd, nrd, nwr, wa); m_apply(OP_LHU, 32'h1001_0002, 0);
    total++;
    if (rd !== 32'h0000_8899 || lat != 2) $display("FAIL lhu_hi: rdata=%h lat=%0d want 00008899 2", rd, lat);
    else pass++;
  endtask

  task automatic test_sub_store;
    int lat, nrd, nwr; logic err; logic [31:0] rd; logic [10:0] wa;
    poke(1, 32'h0000_0000);
    do_req(OP_SB, 32'h1001_0006, 32'h1234_5678, lat, err, rd, nrd, nwr, wa);
    m_apply(OP_SB, 32'h1001_0006, 32'h1234_5678);
    @(negedge clk);
    total++;
    if (mem[1] !== 32'h0078_0000 || lat != 3 || nrd != 1 || nwr != 1 || err !== 1'b0)
      $display("FAIL sb_rmw: word=%h lat=%0d rd=%0d wr=%0d err=%b want 00780000 3 1 1 0",
               mem[1], lat, nrd, nwr, err);
    else pass++;
    total++;
    if (rd !== last_rd) $display("FAIL sb_keeps_rdata: got %h want %h", rd, last_rd);
    else pass++;
  endtask

  task automatic test_top_word;
    int lat, nrd, nwr; logic err; logic [31:0] rd; logic [10:0] wa;
    do_req(OP_SW, 32'h1001_0FFC, 32'hDEAD_BEEF, lat, err, rd, nrd, nwr, wa);
    m_apply(OP_SW, 32'h1001_0FFC, 32'hDEAD_BEEF);
    total++;
    if (wa !== 11'd1023 || nwr != 1 || nrd != 0 || lat != 2 || err !== 1'b0)
      $display("FAIL sw_top: addr=%0d wr=%0d rd=%0d lat=%0d err=%b want 1023 1 0 2 0", wa, nwr, nrd, lat, err);
    else pass++;
    do_req(OP_LW, 32'h1001_0FFC, 32'd0, lat, err, rd, nrd, nwr, wa);
    m_apply(OP_LW, 32'h1001_0FFC, 0);
    total++;
    if (rd !== 32'hDEAD_BEEF || lat != 2) $display("FAIL lw_top: rdata=%h lat=%0d want deadbeef 2", rd, lat);
    else pass++;
  endtask

  task automatic test_errors;
    logic [2:0]  ops [4];
    logic [31:0] adr [4];
    int lat, nrd, nwr; logic err; logic [31:0] rd; logic [10:0] wa;
    ops[0] = OP_LW; adr[0] = 32'h1001_0002;
    ops[1] = OP_SH; adr[1] = 32'h1001_0003;
    ops[2] = OP_LW; adr[2] = 32'h1001_1000;
    ops[3] = OP_LW; adr[3] = 32'h1000_FFFC;
    for (int i = 0; i < 4; i++) begin
      do_req(ops[i], adr[i], 32'hFFFF_FFFF, lat, err, rd, nrd, nwr, wa);
      total++;
      if (err !== 1'b1 || lat != 1 || nrd != 0 || nwr != 0 || rd !== last_rd)
        $display("FAIL err_case%0d: err=%b lat=%0d rd=%0d wr=%0d rdata=%h want 1 1 0 0 %h",
                 i, err, lat, nrd, nwr, rd, last_rd);
      else pass++;
    end
  endtask

  task automatic test_reset_mid_write;
    bit seen;
    poke(2, 32'h1122_3344);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SB; req_addr = BASE + 32'd9; req_wdata = 32'h0000_00AB;
    @(posedge clk); #1; req_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (dmem_write !== 1'b1) $display("FAIL rst_reach_wr: dmem_write=%b want 1", dmem_write);
    else pass++;
    rst_n = 1'b0;
    #1;
    total++;
    if (dmem_write !== 1'b0 || dmem_ena !== 1'b0)
      $display("FAIL rst_async_wr: write=%b ena=%b want 0 0", dmem_write, dmem_ena);
    else pass++;
    @(posedge clk); #2;
    rst_n = 1'b1;
    last_rd = 32'd0;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    total++;
    if (mem[2] !== 32'h1122_3344 || req_ready !== 1'b1 || seen)
      $display("FAIL rst_mid_wr: word=%h ready=%b resp_seen=%b want 11223344 1 0", mem[2], req_ready, seen);
    else pass++;
  endtask

  task automatic test_random;
    logic [2:0] op; logic [31:0] a, wd, e_rd; bit e_err; int e_lat, wi;
    int lat, nrd, nwr; logic err; logic [31:0] rd; logic [10:0] wa;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom_range(0, 7));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = BASE - $urandom_range(1, 64);
        1:       a = BASE + 32'd4096 + $urandom_range(0, 64);
        default: a = BASE + $urandom_range(0, 127);
      endcase
      e_err = m_err(op, a);
      e_lat = m_lat(op, e_err);
      e_rd  = (!e_err && m_is_load(op)) ? m_load(op, a) : last_rd;
      do_req(op, a, wd, lat, err, rd, nrd, nwr, wa);
      m_apply(op, a, wd);
      total++;
      if (err !== e_err || lat != e_lat || rd !== e_rd)
        $display("FAIL rand%0d op=%0d a=%h: err=%b lat=%0d rdata=%h want %b %0d %h",
                 n, op, a, err, lat, rd, e_err, e_lat, e_rd);
      else pass++;
      if (!e_err && !m_is_load(op)) begin
        wi = int'((a - BASE) >> 2);
        @(negedge clk);
        total++;
        if (mem[wi] !== m_word(wi)) $display("FAIL rand%0d_mem[%0d]: got %h want %h", n, wi, mem[wi], m_word(wi));
        else pass++;
      end
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 12;
    logic [31:0] wdk [N];
    logic [31:0] q [$];
    logic [31:0] a, exp;
    logic [2:0]  op;
    int k, acc, nresp, cyc;
    bit rdy;
    for (int i = 0; i < N; i++) wdk[i] = $urandom;
    k = 0; acc = 0; nresp = 0; cyc = 0;
    while ((k < N || q.size() > 0) && cyc < 300) begin
      @(negedge clk); cyc++;
      op = (k % 2 == 0) ? OP_SW : OP_LW;
      a  = BASE + 32'(16 + 4 * ((k / 2) % 3));
      req_valid = (k < N); req_op = op; req_addr = a; req_wdata = wdk[k % N];
      rdy = req_ready;
      @(posedge clk);
      if (rdy && k < N) begin
        m_apply(op, a, wdk[k]);
        exp = last_rd;
        q.push_back(exp);
        k++; acc++;
      end
      #1;
      if (resp_valid) begin
        nresp++;
        exp = (q.size() > 0) ? q.pop_front() : 32'hx;
        total++;
        if (resp_rdata !== exp || resp_err !== 1'b0)
          $display("FAIL b2b_resp%0d: rdata=%h err=%b want %h 0", nresp, resp_rdata, resp_err, exp);
        else pass++;
      end
    end
    req_valid = 1'b0;
    total++;
    if (acc != N || nresp != N) $display("FAIL b2b_count: accepts=%0d resps=%0d want %0d %0d", acc, nresp, N, N);
    else pass++;
  endtask

  initial begin
    last_rd = 32'd0;
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 11'(i); pl_data = $urandom;
      for (int b = 0; b < 4; b++) rb[4*i+b] = 8'(pl_data >> (8*b));
    end
    @(negedge clk);
    pl_en = 1'b0;
    test_reset;
    rst_n = 1'b1;
    test_loads;
    test_sub_store;
    test_top_word;
    test_errors;
    test_reset_mid_write;
    test_random;
    test_back_to_back;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
